debug_frame_serializer: RTL and testbench

DEBUG_FRAME_SERIALIZER -- requirements
Module: debug_frame_serializer

---
 rtl/debug_frame_serializer.sv | 183 ++++++++++++++++++
 tb/tb_debug_frame_serializer.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_frame_serializer.sv
// ============================================================================
// debug_frame_serializer
//
// Purpose:
//   Accepts wide debug frames from a debug controller, buffers them in a
//   small FIFO and hands them byte by byte (MSB first) to a UART transmitter
//   using a start/done handshake. Frames arriving while the FIFO is full are
//   dropped and recorded in a sticky overflow flag.
//
// Parameters:
//   NB_CONTROL_FRAME  width of each incoming frame (nonzero multiple of NB_BYTE)
//   NB_BYTE           width of each byte handed to the transmitter
//   LOG2_DEPTH        frame FIFO holds 2**LOG2_DEPTH frames
//
// Ports:
//   i_clock        single clock, all state changes on the rising edge
//   i_reset        synchronous, active-high reset
//   i_frame        frame from the controller
//   i_frame_valid  one frame per high cycle, no backpressure
//   i_tx_done      one-cycle pulse: current byte fully sent
//   o_tx_data      byte being transmitted
//   o_tx_start     one-cycle pulse requesting transmission of o_tx_data
//   o_busy         high while any frame is queued or being transmitted
//   o_overflow     sticky: at least one frame was dropped
// ============================================================================
module debug_frame_serializer #(
    parameter int NB_CONTROL_FRAME = 32,
    parameter int NB_BYTE          = 8,
    parameter int LOG2_DEPTH       = 4
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic [NB_CONTROL_FRAME-1:0] i_frame,
    input  logic                        i_frame_valid,
    input  logic                        i_tx_done,
    output logic [NB_BYTE-1:0]          o_tx_data,
    output logic                        o_tx_start,
    output logic                        o_busy,
    output logic                        o_overflow
);

    localparam int DEPTH    = 2 ** LOG2_DEPTH;
    localparam int NB_BYTES = NB_CONTROL_FRAME / NB_BYTE;
    localparam int NB_INDEX = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;

    localparam logic [NB_INDEX-1:0]   LAST_INDEX = NB_INDEX'(NB_BYTES - 1);
    localparam logic [NB_INDEX-1:0]   INDEX_ONE  = NB_INDEX'(1);
    localparam logic [LOG2_DEPTH:0]   FULL_COUNT = (LOG2_DEPTH + 1)'(DEPTH);
    localparam logic [LOG2_DEPTH:0]   COUNT_ONE  = (LOG2_DEPTH + 1)'(1);
    localparam logic [LOG2_DEPTH-1:0] PTR_ONE    = LOG2_DEPTH'(1);

    // A frame that is not a whole number of bytes cannot be serialized.
    if ((NB_CONTROL_FRAME % NB_BYTE) != 0 || NB_CONTROL_FRAME < NB_BYTE) begin : g_bad_frame_width
        $error("debug_frame_serializer: NB_CONTROL_FRAME must be a nonzero multiple of NB_BYTE");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_WAIT
    } state_t;

    state_t                      state;

    logic [NB_CONTROL_FRAME-1:0] fifo_mem [DEPTH];
    logic [LOG2_DEPTH-1:0]       wr_ptr;
    logic [LOG2_DEPTH-1:0]       rd_ptr;
    logic [LOG2_DEPTH:0]         count;

    logic                        fifo_full;
    logic                        fifo_empty;
    logic                        push;
    logic                        pop;
    logic [NB_CONTROL_FRAME-1:0] fifo_head;

    logic [NB_CONTROL_FRAME-1:0] shift_reg;
    logic [NB_CONTROL_FRAME-1:0] shift_next;
    logic [NB_INDEX-1:0]         byte_index;

    // Full/empty come from the registered occupancy only, so a pop in the
    // same cycle never frees a slot for a push arriving while full.
    assign fifo_full  = (count == FULL_COUNT);
    assign fifo_empty = (count == '0);
    assign push       = i_frame_valid && !fifo_full;
    // LOAD is only ever entered with the FIFO non-empty, so it always pops.
    assign pop        = (state == ST_LOAD);
    assign fifo_head  = fifo_mem[rd_ptr];
    assign shift_next = shift_reg << NB_BYTE;

    assign o_busy     = (state != ST_IDLE) || !fifo_empty;

    // Frame storage. The contents need no reset because the pointers and
    // occupancy define which entries are meaningful.
    always_ff @(posedge i_clock) begin
        if (!i_reset && push) begin
            fifo_mem[wr_ptr] <= i_frame;
        end
    end

    // Pointer and occupancy bookkeeping. Pointers wrap naturally at the
    // FIFO depth; a simultaneous push and pop leaves occupancy unchanged.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + COUNT_ONE;
                2'b01:   count <= count - COUNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Sticky drop indicator: any frame offered while the FIFO is full is
    // lost, even if the serializer pops in that same cycle.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_overflow <= 1'b0;
        end else if (i_frame_valid && fifo_full) begin
            o_overflow <= 1'b1;
        end
    end

    // Serializer FSM. The outputs are registered: o_tx_start and o_tx_data
    // are prepared on the transition into SEND so they are valid during the
    // SEND cycle itself. o_tx_data then holds until the next byte is
    // prepared, which keeps it stable through WAIT. Done pulses are only
    // looked at in WAIT, so strays in other states have no effect.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state      <= ST_IDLE;
            shift_reg  <= '0;
            byte_index <= '0;
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
        end else begin
            o_tx_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    shift_reg  <= fifo_head;
                    byte_index <= '0;
                    o_tx_data  <= fifo_head[NB_CONTROL_FRAME-1 -: NB_BYTE];
                    o_tx_start <= 1'b1;
                    state      <= ST_SEND;
                end
                ST_SEND: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (i_tx_done) begin
                        if (byte_index == LAST_INDEX) begin
                            state <= fifo_empty ? ST_IDLE : ST_LOAD;
                        end else begin
                            shift_reg  <= shift_next;
                            byte_index <= byte_index + INDEX_ONE;
                            o_tx_data  <= shift_next[NB_CONTROL_FRAME-1 -: NB_BYTE];
                            o_tx_start <= 1'b1;
                            state      <= ST_SEND;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debug_frame_serializer.sv
// ============================================================================
// tb_debug_frame_serializer
//
// Purpose:
//   Scoreboard bench for debug_frame_serializer. Stimulus pushes the bytes
//   each accepted frame should produce into an expected queue; a monitor
//   pops and compares on every o_tx_start; a UART responder answers each
//   start with an i_tx_done pulse after a chosen delay.
// ============================================================================
module tb_debug_frame_serializer;

    localparam int NB_CONTROL_FRAME = 32;
    localparam int NB_BYTE          = 8;
    localparam int LOG2_DEPTH       = 4;
    localparam int DEPTH            = 16;
    localparam int NB_BYTES         = 4;

    logic                        i_clock = 1'b0;
    logic                        i_reset;
    logic [NB_CONTROL_FRAME-1:0] i_frame;
    logic                        i_frame_valid;
    logic                        i_tx_done;
    logic [NB_BYTE-1:0]          o_tx_data;
    logic                        o_tx_start;
    logic                        o_busy;
    logic                        o_overflow;

    logic resp_done;
    logic stray_done;

    assign i_tx_done = resp_done | stray_done;

    debug_frame_serializer #(
        .NB_CONTROL_FRAME(NB_CONTROL_FRAME),
        .NB_BYTE         (NB_BYTE),
        .LOG2_DEPTH      (LOG2_DEPTH)
    ) dut (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_frame      (i_frame),
        .i_frame_valid(i_frame_valid),
        .i_tx_done    (i_tx_done),
        .o_tx_data    (o_tx_data),
        .o_tx_start   (o_tx_start),
        .o_busy       (o_busy),
        .o_overflow   (o_overflow)
    );

    always #5 i_clock = ~i_clock;

    typedef struct {
        logic [7:0] data;
        bit         first;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int checks          = 0;
    int errors          = 0;
    int cyc             = 0;
    int start_count     = 0;
    int done_count      = 0;
    int frames_started  = 0;
    int last_first_cyc  = 0;
    int last_done_cyc   = -100;
    int burst_start_cyc = 0;

    int  resp_delay    = 5;
    bit  rand_delay    = 1'b0;
    bit  hold_done     = 1'b0;
    bit  stray_in_send = 1'b0;
    bit  gap_check     = 1'b0;
    bit  resp_abort    = 1'b0;

    logic [7:0] resp_held;
    int         resp_d;

    // Free-running cycle number, advanced on every rising edge.
    always @(posedge i_clock) begin
        cyc++;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Reference model: a frame turns into its bytes, most significant first.
    task automatic pushFrame(input logic [31:0] frame);
        exp_t e;
        for (int k = 0; k < NB_BYTES; k++) begin
            e.data  = 8'(frame >> (8 * (NB_BYTES - 1 - k)));
            e.first = (k == 0);
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge i_clock);
            #1;
        end
    endtask

    // One valid cycle; successive calls give back-to-back frames.
    task automatic applyStimulus(input logic [31:0] frame, input bit expect_sent);
        i_frame       = frame;
        i_frame_valid = 1'b1;
        if (expect_sent) begin
            pushFrame(frame);
        end
        @(posedge i_clock);
        #1;
        i_frame_valid = 1'b0;
        i_frame       = $urandom;
    endtask

    task automatic waitDrain(input string name, input int budget);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || o_busy !== 1'b0) && t < budget) begin
            @(posedge i_clock);
            #1;
            t++;
        end
        checkOutput({name, "_drain_in_time"}, (t < budget), 1);
    endtask

    // Two reset cycles with random inputs, then all outputs must be zero.
    task automatic doReset(input string name);
        i_reset = 1'b1;
        repeat (2) begin
            i_frame_valid = 1'($urandom);
            i_frame       = $urandom;
            stray_done    = 1'($urandom);
            @(posedge i_clock);
            #1;
        end
        i_reset       = 1'b0;
        i_frame_valid = 1'b0;
        stray_done    = 1'b0;
        exp_q.delete();
        checkOutput({name, "_tx_data"},  o_tx_data,  0);
        checkOutput({name, "_tx_start"}, o_tx_start, 0);
        checkOutput({name, "_busy"},     o_busy,     0);
        checkOutput({name, "_overflow"}, o_overflow, 0);
    endtask

    // Monitor: every start must match the next expected byte.
    always @(negedge i_clock) begin
        if (o_tx_start === 1'b1) begin
            start_count++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_start: got byte %0h, expected no byte (cycle %0d)", o_tx_data, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("tx_data", o_tx_data, mon_e.data);
                if (mon_e.first) begin
                    frames_started++;
                    last_first_cyc = cyc;
                end
                if (gap_check && last_done_cyc > burst_start_cyc) begin
                    checkOutput("start_gap", cyc - last_done_cyc, mon_e.first ? 2 : 1);
                end
            end
        end
    end

    // UART responder: answers each start with a done pulse after a delay,
    // optionally injecting a stray done during the SEND cycle.
    initial begin
        resp_done = 1'b0;
        forever begin
            @(negedge i_clock);
            if (o_tx_start === 1'b1) begin
                resp_held = o_tx_data;
                resp_d    = rand_delay ? int'($urandom_range(1, 6)) : resp_delay;
                if (stray_in_send) begin
                    stray_done = 1'b1;
                end
                @(posedge i_clock);
                #1;
                stray_done = 1'b0;
                repeat (resp_d - 1) begin
                    @(posedge i_clock);
                    #1;
                end
                while (hold_done) begin
                    @(posedge i_clock);
                    #1;
                end
                if (!resp_abort) begin
                    checkOutput("tx_data_stable", o_tx_data, resp_held);
                end
                resp_done     = 1'b1;
                last_done_cyc = cyc;
                done_count++;
                @(posedge i_clock);
                #1;
                resp_done = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c0;
        int s0;
        int d0;
        int p0;
        int pushed;
        int t;

        i_reset       = 1'b1;
        i_frame       = '0;
        i_frame_valid = 1'b0;
        stray_done    = 1'b0;
        idle(1);

        $display("[TB] reset with random inputs");
        doReset("reset");
        idle(1);
        checkOutput("reset_busy_next", o_busy, 0);

        $display("[TB] single frame");
        resp_delay = 5;
        s0 = start_count;
        d0 = done_count;
        c0 = cyc;
        applyStimulus(32'hA1B2C3D4, 1'b1);
        waitDrain("single", 200);
        checkOutput("single_latency", last_first_cyc - c0, 3);
        checkOutput("single_starts", start_count - s0, 4);
        checkOutput("single_dones", done_count - d0, 4);
        checkOutput("single_overflow", o_overflow, 0);

        $display("[TB] burst of three frames");
        gap_check       = 1'b1;
        burst_start_cyc = cyc;
        s0              = start_count;
        applyStimulus(32'h11111111, 1'b1);
        applyStimulus(32'h22222222, 1'b1);
        applyStimulus(32'h33333333, 1'b1);
        waitDrain("burst", 400);
        gap_check = 1'b0;
        checkOutput("burst_starts", start_count - s0, 12);
        checkOutput("burst_overflow", o_overflow, 0);

        $display("[TB] overflow");
        hold_done = 1'b1;
        s0        = start_count;
        for (int i = 0; i < DEPTH + 2; i++) begin
            applyStimulus($urandom, (i < DEPTH + 1));
        end
        idle(2);
        checkOutput("overflow_set", o_overflow, 1);
        checkOutput("overflow_busy", o_busy, 1);
        hold_done = 1'b0;
        waitDrain("overflow", 3000);
        idle(5);
        checkOutput("overflow_bytes", start_count - s0, 68);
        checkOutput("overflow_sticky", o_overflow, 1);
        doReset("overflow_clear");

        $display("[TB] reset mid-frame");
        resp_delay = 5;
        d0         = done_count;
        applyStimulus(32'hDEADBEEF, 1'b1);
        applyStimulus($urandom, 1'b1);
        applyStimulus($urandom, 1'b1);
        t = 0;
        while (done_count - d0 < 2 && t < 300) begin
            idle(1);
            t++;
        end
        checkOutput("midframe_two_dones", (done_count - d0 >= 2), 1);
        hold_done  = 1'b1;
        resp_abort = 1'b1;
        idle(3);
        doReset("midframe");
        idle(6);
        checkOutput("midframe_fifo_flushed", o_busy, 0);
        hold_done = 1'b0;
        idle(4);
        resp_abort = 1'b0;
        idle(2);
        s0 = start_count;
        applyStimulus(32'hCAFEF00D, 1'b1);
        waitDrain("after_reset", 200);
        checkOutput("after_reset_starts", start_count - s0, 4);

        $display("[TB] stray done pulses");
        s0 = start_count;
        for (int i = 0; i < 3; i++) begin
            stray_done = 1'b1;
            idle(1);
            stray_done = 1'b0;
            idle(1);
        end
        checkOutput("stray_idle_busy", o_busy, 0);
        checkOutput("stray_idle_starts", start_count - s0, 0);
        stray_in_send = 1'b1;
        applyStimulus(32'h5A6B7C8D, 1'b1);
        waitDrain("stray_send", 200);
        stray_in_send = 1'b0;
        checkOutput("stray_send_starts", start_count - s0, 4);

        $display("[TB] randomized traffic");
        rand_delay = 1'b1;
        p0         = frames_started;
        pushed     = 0;
        for (int i = 0; i < 60; i++) begin
            t = 0;
            while (pushed - (frames_started - p0) >= DEPTH - 1 && t < 1000) begin
                idle(1);
                t++;
            end
            checkOutput("random_throttle", (t < 1000), 1);
            stray_in_send = 1'($urandom);
            applyStimulus($urandom, 1'b1);
            pushed++;
            idle($urandom_range(0, 3));
        end
        waitDrain("random", 5000);
        stray_in_send = 1'b0;
        rand_delay    = 1'b0;
        checkOutput("random_frames", frames_started - p0, 60);
        checkOutput("random_overflow", o_overflow, 0);
        checkOutput("final_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
